// File: rtl/lnrv_icb_defines.sv
// Shared ICB widths, the grant-index width helper and the default outstanding
// depth used by the ICB arbiter and its index FIFO.
package lnrv_icb_defines;

    localparam int ICB_ADDR_WIDTH     = 32;
    localparam int ICB_DATA_WIDTH     = 32;
    localparam int ICB_DEF_OUTS_DEPTH = 4;

    // Width needed to hold an index in 0..n-1, never narrower than one bit.
    function automatic int lnrv_clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lnrv_icb_idx_fifo.sv
// Synchronous FIFO of grant indices; one entry per command the target has
// accepted but not yet answered, so responses can be steered in order.
module lnrv_icb_idx_fifo
    import lnrv_icb_defines::*;
#(
    parameter int P_WIDTH = 1,
    parameter int P_DEPTH = ICB_DEF_OUTS_DEPTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push_i,
    input  logic [P_WIDTH-1:0] push_data_i,
    input  logic               pop_i,
    output logic [P_WIDTH-1:0] pop_data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PW = $clog2(P_DEPTH);
    localparam int CW = PW + 1;

    logic [P_WIDTH-1:0] mem_q [P_DEPTH];
    logic [P_WIDTH-1:0] mem_d [P_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign full_o     = (count_q == CW'(P_DEPTH));
    assign empty_o    = (count_q == '0);
    assign pop_data_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lnrv_icb_arbiter.sv
// N-master to 1-slave ICB arbiter: round-robin command grant locked across
// stalls, responses routed back in order through a FIFO of grant indices.
module lnrv_icb_arbiter
    import lnrv_icb_defines::*;
#(
    parameter int P_MST_NUM    = 2,
    parameter int P_ADDR_WIDTH = ICB_ADDR_WIDTH,
    parameter int P_DATA_WIDTH = ICB_DATA_WIDTH,
    parameter int P_OUTS_DEPTH = ICB_DEF_OUTS_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  reset_n,

    input  logic [P_MST_NUM-1:0]                  m_icb_cmd_vld,
    output logic [P_MST_NUM-1:0]                  m_icb_cmd_rdy,
    input  logic [P_MST_NUM-1:0]                  m_icb_cmd_write,
    input  logic [P_MST_NUM*P_ADDR_WIDTH-1:0]     m_icb_cmd_addr,
    input  logic [P_MST_NUM*P_DATA_WIDTH-1:0]     m_icb_cmd_wdata,
    input  logic [P_MST_NUM*(P_DATA_WIDTH/8)-1:0] m_icb_cmd_wstrb,
    output logic [P_MST_NUM-1:0]                  m_icb_rsp_vld,
    input  logic [P_MST_NUM-1:0]                  m_icb_rsp_rdy,
    output logic [P_MST_NUM-1:0]                  m_icb_rsp_err,
    output logic [P_DATA_WIDTH-1:0]               m_icb_rsp_rdata,

    output logic                                  s_icb_cmd_vld,
    input  logic                                  s_icb_cmd_rdy,
    output logic                                  s_icb_cmd_write,
    output logic [P_ADDR_WIDTH-1:0]               s_icb_cmd_addr,
    output logic [P_DATA_WIDTH-1:0]               s_icb_cmd_wdata,
    output logic [P_DATA_WIDTH/8-1:0]             s_icb_cmd_wstrb,
    input  logic                                  s_icb_rsp_vld,
    output logic                                  s_icb_rsp_rdy,
    input  logic                                  s_icb_rsp_err,
    input  logic [P_DATA_WIDTH-1:0]               s_icb_rsp_rdata
);

    localparam int IW = lnrv_clog2(P_MST_NUM);
    localparam int AW = P_ADDR_WIDTH;
    localparam int DW = P_DATA_WIDTH;
    localparam int SW = P_DATA_WIDTH / 8;

    // Handshake rule on both channels: a beat transfers on the rising edge
    // where vld and rdy are both high; a master holds its command fields
    // stable from the first vld until that beat.

    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                 lock_q, lock_d;
    logic [IW-1:0]        lock_idx_q, lock_idx_d;

    logic [P_MST_NUM-1:0] vld_rot;
    logic [IW-1:0]        rr_off;
    logic [IW:0]          grant_sum;
    logic [IW-1:0]        rr_pick;
    logic [IW-1:0]        grant;
    logic [IW-1:0]        head;
    logic                 any_req;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 cmd_hs;
    logic                 cmd_stall;
    logic                 rsp_hs;

    // Rotate the request vector so the highest-priority master sits at bit 0,
    // take the lowest set bit, then rotate the offset back.
    always_comb begin
        vld_rot   = P_MST_NUM'({m_icb_cmd_vld, m_icb_cmd_vld} >> rr_ptr_q);
        rr_off    = '0;
        for (int k = P_MST_NUM - 1; k >= 0; k--) begin
            if (vld_rot[k]) begin
                rr_off = IW'(k);
            end
        end
        grant_sum = {1'b0, rr_ptr_q} + {1'b0, rr_off};
        if (grant_sum >= (IW+1)'(P_MST_NUM)) begin
            grant_sum = grant_sum - (IW+1)'(P_MST_NUM);
        end
        rr_pick   = grant_sum[IW-1:0];
    end

    assign grant   = lock_q ? lock_idx_q : rr_pick;
    assign any_req = |m_icb_cmd_vld;

    // New commands are refused while the index FIFO is full, even if a
    // response frees a slot in the same cycle: no full-to-ready bypass.
    assign s_icb_cmd_vld = any_req && !fifo_full;

    always_comb begin
        s_icb_cmd_write = 1'b0;
        s_icb_cmd_addr  = '0;
        s_icb_cmd_wdata = '0;
        s_icb_cmd_wstrb = '0;
        m_icb_cmd_rdy   = '0;
        for (int k = 0; k < P_MST_NUM; k++) begin
            if (grant == IW'(k)) begin
                s_icb_cmd_write  = m_icb_cmd_write[k];
                s_icb_cmd_addr   = m_icb_cmd_addr[k*AW +: AW];
                s_icb_cmd_wdata  = m_icb_cmd_wdata[k*DW +: DW];
                s_icb_cmd_wstrb  = m_icb_cmd_wstrb[k*SW +: SW];
                m_icb_cmd_rdy[k] = s_icb_cmd_vld && s_icb_cmd_rdy;
            end
        end
    end

    // A response with nothing outstanding is ignored: no master sees it and
    // the target is not acknowledged.
    always_comb begin
        m_icb_rsp_vld = '0;
        s_icb_rsp_rdy = 1'b0;
        for (int k = 0; k < P_MST_NUM; k++) begin
            if (head == IW'(k)) begin
                m_icb_rsp_vld[k] = s_icb_rsp_vld && !fifo_empty;
                s_icb_rsp_rdy    = m_icb_rsp_rdy[k] && !fifo_empty;
            end
        end
    end

    assign m_icb_rsp_err   = {P_MST_NUM{s_icb_rsp_err}};
    assign m_icb_rsp_rdata = s_icb_rsp_rdata;

    assign cmd_hs    = s_icb_cmd_vld && s_icb_cmd_rdy;
    assign cmd_stall = s_icb_cmd_vld && !s_icb_cmd_rdy;
    assign rsp_hs    = s_icb_rsp_vld && s_icb_rsp_rdy;

    // A stalled grant is pinned so a late higher-priority request cannot
    // change the command already presented to the target.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (cmd_hs) begin
            rr_ptr_d = (grant == IW'(P_MST_NUM - 1)) ? '0 : grant + IW'(1);
            lock_d   = 1'b0;
        end else if (cmd_stall) begin
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    lnrv_icb_idx_fifo #(
        .P_WIDTH (IW),
        .P_DEPTH (P_OUTS_DEPTH)
    ) u_idx_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (cmd_hs),
        .push_data_i (grant),
        .pop_i       (rsp_hs),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_lnrv_icb_arbiter.sv
// Randomized bench for lnrv_icb_arbiter with three masters, a behavioural
// slave and an ordered response scoreboard.
module tb_lnrv_icb_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int D  = 4;
    localparam int EW = 8 + AW;

    logic              clk;
    logic              reset_n;
    logic [N-1:0]      m_cmd_vld;
    logic [N-1:0]      m_cmd_rdy;
    logic [N-1:0]      m_cmd_write;
    logic [N*AW-1:0]   m_cmd_addr;
    logic [N*DW-1:0]   m_cmd_wdata;
    logic [N*SW-1:0]   m_cmd_wstrb;
    logic [N-1:0]      m_rsp_vld;
    logic [N-1:0]      m_rsp_rdy;
    logic [N-1:0]      m_rsp_err;
    logic [DW-1:0]     m_rsp_rdata;
    logic              s_cmd_vld;
    logic              s_cmd_rdy;
    logic              s_cmd_write;
    logic [AW-1:0]     s_cmd_addr;
    logic [DW-1:0]     s_cmd_wdata;
    logic [SW-1:0]     s_cmd_wstrb;
    logic              s_rsp_vld;
    logic              s_rsp_rdy;
    logic              s_rsp_err;
    logic [DW-1:0]     s_rsp_rdata;

    lnrv_icb_arbiter #(
        .P_MST_NUM    (N),
        .P_ADDR_WIDTH (AW),
        .P_DATA_WIDTH (DW),
        .P_OUTS_DEPTH (D)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .m_icb_cmd_vld   (m_cmd_vld),
        .m_icb_cmd_rdy   (m_cmd_rdy),
        .m_icb_cmd_write (m_cmd_write),
        .m_icb_cmd_addr  (m_cmd_addr),
        .m_icb_cmd_wdata (m_cmd_wdata),
        .m_icb_cmd_wstrb (m_cmd_wstrb),
        .m_icb_rsp_vld   (m_rsp_vld),
        .m_icb_rsp_rdy   (m_rsp_rdy),
        .m_icb_rsp_err   (m_rsp_err),
        .m_icb_rsp_rdata (m_rsp_rdata),
        .s_icb_cmd_vld   (s_cmd_vld),
        .s_icb_cmd_rdy   (s_cmd_rdy),
        .s_icb_cmd_write (s_cmd_write),
        .s_icb_cmd_addr  (s_cmd_addr),
        .s_icb_cmd_wdata (s_cmd_wdata),
        .s_icb_cmd_wstrb (s_cmd_wstrb),
        .s_icb_rsp_vld   (s_rsp_vld),
        .s_icb_rsp_rdy   (s_rsp_rdy),
        .s_icb_rsp_err   (s_rsp_err),
        .s_icb_rsp_rdata (s_rsp_rdata)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- shared bench state ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int p_new    = 0;
    int p_srdy   = 100;
    int p_srsp   = 100;
    int p_mrdy   = 100;

    logic [N-1:0]    acc;
    bit              rsp_done;
    logic [AW-1:0]   slave_q[$];
    logic [EW-1:0]   exp_q[$];

    // Reference model: priority start, pinned master (-1 = none) and the
    // list of masters owed a response, oldest first.
    int              ref_rr   = 0;
    int              ref_lock = -1;
    int              owner_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rsp_data(input logic [AW-1:0] a);
        return a ^ 32'hA5C3_0F1E;
    endfunction

    function automatic logic rsp_err(input logic [AW-1:0] a);
        return ^a;
    endfunction

    // ---------------- reference model and cycle checker ----------------
    int           g;
    int           h;
    bit           found;
    bit           full;
    bit           exp_svld;
    bit           has;
    bit           exp_srr;
    logic [N-1:0] exp_mrdy;
    logic [N-1:0] exp_mrv;

    always @(negedge clk) begin
        if (chk_en) begin
            full  = (owner_q.size() >= D);
            g     = 0;
            found = 1'b0;
            if (ref_lock >= 0) begin
                g     = ref_lock;
                found = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!found && m_cmd_vld[(ref_rr + k) % N]) begin
                        g     = (ref_rr + k) % N;
                        found = 1'b1;
                    end
                end
            end
            exp_svld = (m_cmd_vld != '0) && !full;
            exp_mrdy = '0;
            if (exp_svld && s_cmd_rdy) exp_mrdy[g] = 1'b1;
            check("s_cmd_vld", 64'(s_cmd_vld), 64'(exp_svld));
            check("m_cmd_rdy", 64'(m_cmd_rdy), 64'(exp_mrdy));
            if (exp_svld) begin
                check("s_cmd_addr",  64'(s_cmd_addr),  64'(m_cmd_addr[g*AW +: AW]));
                check("s_cmd_write", 64'(s_cmd_write), 64'(m_cmd_write[g]));
                check("s_cmd_wdata", 64'(s_cmd_wdata), 64'(m_cmd_wdata[g*DW +: DW]));
                check("s_cmd_wstrb", 64'(s_cmd_wstrb), 64'(m_cmd_wstrb[g*SW +: SW]));
            end

            has     = (owner_q.size() > 0);
            h       = has ? owner_q[0] : 0;
            exp_mrv = '0;
            if (s_rsp_vld && has) exp_mrv[h] = 1'b1;
            exp_srr = has && m_rsp_rdy[h];
            check("m_rsp_vld", 64'(m_rsp_vld), 64'(exp_mrv));
            check("s_rsp_rdy", 64'(s_rsp_rdy), 64'(exp_srr));
            check("m_rsp_err_bcast", 64'(m_rsp_err), 64'({N{s_rsp_err}}));

            if (s_rsp_vld && exp_srr) void'(owner_q.pop_front());
            if (exp_svld && s_cmd_rdy) begin
                owner_q.push_back(g);
                exp_q.push_back({8'(g), m_cmd_addr[g*AW +: AW]});
                ref_rr   = (g + 1) % N;
                ref_lock = -1;
            end else if (exp_svld) begin
                ref_lock = g;
            end
        end
    end

    // ---------------- bus-functional observers (masters and slave) ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < N; i++) acc[i] = m_cmd_vld[i] && m_cmd_rdy[i];
            rsp_done = s_rsp_vld && s_rsp_rdy;
            if (rsp_done && slave_q.size() > 0) void'(slave_q.pop_front());
            if (s_cmd_vld && s_cmd_rdy) slave_q.push_back(s_cmd_addr);
        end
    end

    // ---------------- response scoreboard monitor ----------------
    logic [EW-1:0] exp_e;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                if (m_rsp_vld[i] && m_rsp_rdy[i]) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 64'(i + 1), 64'(0));
                    end else begin
                        exp_e = exp_q.pop_front();
                        check("rsp_master", 64'(i), 64'(exp_e[EW-1:AW]));
                        check("rsp_rdata", 64'(m_rsp_rdata), 64'(rsp_data(exp_e[AW-1:0])));
                        check("rsp_err", 64'(m_rsp_err[i]), 64'(rsp_err(exp_e[AW-1:0])));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_masters();
        for (int i = 0; i < N; i++) begin
            if (m_cmd_vld[i] && acc[i]) m_cmd_vld[i] = 1'b0;
            if (!m_cmd_vld[i] && ($urandom_range(99) < p_new)) begin
                m_cmd_vld[i]           = 1'b1;
                m_cmd_write[i]         = 1'($urandom_range(1));
                m_cmd_addr[i*AW +: AW] = $urandom;
                m_cmd_wdata[i*DW +: DW] = $urandom;
                m_cmd_wstrb[i*SW +: SW] = SW'($urandom_range(15));
            end
            m_rsp_rdy[i] = ($urandom_range(99) < p_mrdy);
        end
    endtask

    task automatic drive_slave();
        s_cmd_rdy = ($urandom_range(99) < p_srdy);
        if (s_rsp_vld && rsp_done) s_rsp_vld = 1'b0;
        if (!s_rsp_vld && slave_q.size() > 0 && ($urandom_range(99) < p_srsp)) begin
            s_rsp_vld   = 1'b1;
            s_rsp_rdata = rsp_data(slave_q[0]);
            s_rsp_err   = rsp_err(slave_q[0]);
        end
    endtask

    // ---------------- main sequence ----------------
    int drain_cnt;

    initial begin
        reset_n     = 1'b0;
        m_cmd_vld   = '0;
        m_cmd_write = '0;
        m_cmd_addr  = '0;
        m_cmd_wdata = '0;
        m_cmd_wstrb = '0;
        m_rsp_rdy   = '0;
        s_cmd_rdy   = 1'b0;
        s_rsp_vld   = 1'b0;
        s_rsp_err   = 1'b0;
        s_rsp_rdata = '0;
        acc         = '0;
        rsp_done    = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_s_cmd_vld", 64'(s_cmd_vld), 64'(0));
        check("reset_m_cmd_rdy", 64'(m_cmd_rdy), 64'(0));
        check("reset_m_rsp_vld", 64'(m_rsp_vld), 64'(0));
        check("reset_s_rsp_rdy", 64'(s_rsp_rdy), 64'(0));

        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        // Idle, then a stray response with nothing outstanding.
        s_cmd_rdy = 1'b1;
        m_rsp_rdy = '1;
        repeat (3) @(posedge clk);
        #1;
        s_rsp_vld   = 1'b1;
        s_rsp_rdata = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        s_rsp_vld = 1'b0;

        for (int c = 0; c < 2400; c++) begin
            case (c / 400)
                0: begin p_new = 60; p_srdy = 70;  p_srsp = 50; p_mrdy = 70;  end
                1: begin p_new = 90; p_srdy = 100; p_srsp = 5;  p_mrdy = 100; end
                2: begin p_new = 70; p_srdy = 20;  p_srsp = 60; p_mrdy = 80;  end
                3: begin p_new = 70; p_srdy = 80;  p_srsp = 80; p_mrdy = 20;  end
                4: begin p_new = 100; p_srdy = 100; p_srsp = 100; p_mrdy = 100; end
                default: begin p_new = 40; p_srdy = 50; p_srsp = 50; p_mrdy = 50; end
            endcase
            @(posedge clk);
            #1;
            drive_masters();
            drive_slave();
        end

        p_new  = 0;
        p_srdy = 100;
        p_srsp = 100;
        p_mrdy = 100;
        drain_cnt = 0;
        while ((exp_q.size() != 0 || m_cmd_vld != '0 || slave_q.size() != 0) && drain_cnt < 400) begin
            @(posedge clk);
            #1;
            drive_masters();
            drive_slave();
            drain_cnt++;
        end
        check("drain_done", 64'(exp_q.size() + slave_q.size()), 64'(0));
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
